degradado_param: RTL and testbench

Parametrised background-fade generator for the VGA path. It derives a once-per-frame tick from the vertical address and divides it by a programmable frame count. On each step it walks an RGB colour between run-time minimum and maximum bounds, in bounce, wrap or hold mode. It drives the registered, blanking-gated background colour to the pixel mux in place of the fixed-range fade.

---
 rtl/degradado_pkg.sv | 32 +++
 rtl/degradado_param_prescaler.sv | 43 ++++
 rtl/degradado_param.sv | 152 +++++++++++++++
 tb/tb_degradado_param.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/degradado_pkg.sv
// Shared definitions for the parametrised background-fade generator.
// Mode codes, channel indices, direction state and a channel extractor.
package degradado_pkg;

    localparam logic [1:0] MODE_HOLD   = 2'd0;
    localparam logic [1:0] MODE_BOUNCE = 2'd1;
    localparam logic [1:0] MODE_WRAP   = 2'd2;

    localparam int CH_B = 0;
    localparam int CH_G = 1;
    localparam int CH_R = 2;

    localparam int MAX_CH_W = 16;

    typedef enum logic {
        DIR_UP   = 1'b0,
        DIR_DOWN = 1'b1
    } dir_e;

    // Colour words are zero-extended into a fixed container so one
    // function serves every CH_W up to MAX_CH_W.
    function automatic logic [MAX_CH_W-1:0] get_ch(
        input logic [3*MAX_CH_W-1:0] c,
        input int unsigned           n,
        input int unsigned           w
    );
        logic [MAX_CH_W-1:0] mask;
        mask = (MAX_CH_W'(1) << w) - MAX_CH_W'(1);
        return MAX_CH_W'(c >> (n * w)) & mask;
    endfunction

endpackage

// File: rtl/degradado_param_prescaler.sv
// Once-per-frame tick from the vertical address, divided down to a
// colour-step strobe.
module frame_tick_prescaler #(
    parameter int V_W             = 10,
    parameter int LINE_TRIGGER    = 1,
    parameter int FRAMES_PER_STEP = 4
) (
    input  logic           CLK,
    input  logic           RST,
    input  logic [V_W-1:0] ADDRV,
    input  logic           enable,
    output logic           step
);

    localparam int CNT_W =
        (FRAMES_PER_STEP > 1) ? $clog2(FRAMES_PER_STEP) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FRAMES_PER_STEP - 1);

    logic             match_now;
    logic             match_q;
    logic             tick_q;
    logic [CNT_W-1:0] cnt_q;
    logic             cnt_last;

    assign match_now = (ADDRV == V_W'(LINE_TRIGGER));
    assign cnt_last  = (cnt_q == CNT_LAST);
    assign step      = tick_q & enable & cnt_last;

    always_ff @(posedge CLK) begin
        if (RST) begin
            match_q <= 1'b0;
            tick_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            match_q <= match_now;
            tick_q  <= match_now & ~match_q;
            if (tick_q && enable) begin
                cnt_q <= cnt_last ? '0 : cnt_q + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/degradado_param.sv
// Background-fade generator: walks an RGB colour between run-time
// bounds once per programmable number of frames.
module degradado_param
    import degradado_pkg::*;
#(
    parameter int CH_W            = 4,
    parameter int V_W             = 10,
    parameter int LINE_TRIGGER    = 1,
    parameter int FRAMES_PER_STEP = 4
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              video_ON,
    input  logic [V_W-1:0]    ADDRV,
    input  logic              enable,
    input  logic [1:0]        mode,
    input  logic [3*CH_W-1:0] color_min,
    input  logic [3*CH_W-1:0] color_max,
    output logic [3*CH_W-1:0] COLOR_OUT,
    output logic              step_tick,
    output logic              dir_down
);

    localparam int COL_W = 3 * CH_W;
    localparam int EXT_W = 3 * MAX_CH_W;

    logic             step;
    logic [COL_W-1:0] color_q;
    dir_e             dir_q;

    logic [CH_W-1:0]  cur [3];
    logic [CH_W-1:0]  lo  [3];
    logic [CH_W-1:0]  hi  [3];
    logic [CH_W-1:0]  clp [3];
    logic [CH_W-1:0]  inc [3];
    logic [CH_W-1:0]  dec [3];
    logic [CH_W-1:0]  nxt [3];
    logic [2:0]       oor;
    logic             at_max;
    logic             at_min;
    logic             inc_done;
    logic             dec_done;
    dir_e             nxt_dir;
    logic [COL_W-1:0] nxt_col;

    frame_tick_prescaler #(
        .V_W             (V_W),
        .LINE_TRIGGER    (LINE_TRIGGER),
        .FRAMES_PER_STEP (FRAMES_PER_STEP)
    ) u_prescaler (
        .CLK    (CLK),
        .RST    (RST),
        .ADDRV  (ADDRV),
        .enable (enable),
        .step   (step)
    );

    always_comb begin
        for (int i = 0; i < 3; i++) begin
            cur[i] = CH_W'(get_ch(EXT_W'(color_q), i, CH_W));
            lo[i]  = CH_W'(get_ch(EXT_W'(color_min), i, CH_W));
            hi[i]  = CH_W'(get_ch(EXT_W'(color_max), i, CH_W));
        end
    end

    always_comb begin
        oor = '0;
        for (int i = 0; i < 3; i++) begin
            clp[i] = cur[i];
            if (cur[i] < lo[i]) begin
                clp[i] = lo[i];
                oor[i] = 1'b1;
            end else if (cur[i] > hi[i]) begin
                clp[i] = hi[i];
                oor[i] = 1'b1;
            end
        end
        at_max = (color_q == color_max);
        at_min = (color_q == color_min);
    end

    // Ascent fills B first; descent drains R first.
    always_comb begin
        inc_done = 1'b0;
        dec_done = 1'b0;
        for (int i = 0; i < 3; i++) begin
            inc[i] = cur[i];
            dec[i] = cur[i];
        end
        for (int i = 0; i < 3; i++) begin
            if (!inc_done && cur[i] < hi[i]) begin
                inc[i]   = cur[i] + CH_W'(1);
                inc_done = 1'b1;
            end
        end
        for (int i = 2; i >= 0; i--) begin
            if (!dec_done && cur[i] > lo[i]) begin
                dec[i]   = cur[i] - CH_W'(1);
                dec_done = 1'b1;
            end
        end
    end

    always_comb begin
        nxt     = cur;
        nxt_dir = dir_q;
        if (|oor) begin
            nxt = clp;
            if (mode == MODE_WRAP) begin
                nxt_dir = DIR_UP;
            end
        end else begin
            unique case (1'b1)
                (mode == MODE_BOUNCE): begin
                    if (dir_q == DIR_UP) begin
                        if (at_max) nxt_dir = DIR_DOWN;
                        else        nxt     = inc;
                    end else begin
                        if (at_min) nxt_dir = DIR_UP;
                        else        nxt     = dec;
                    end
                end
                (mode == MODE_WRAP): begin
                    nxt_dir = DIR_UP;
                    nxt     = at_max ? lo : inc;
                end
                default: begin
                end
            endcase
        end
        nxt_col = {nxt[CH_R], nxt[CH_G], nxt[CH_B]};
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            color_q   <= '0;
            dir_q     <= DIR_UP;
            step_tick <= 1'b0;
            COLOR_OUT <= '0;
        end else begin
            step_tick <= step;
            if (step) begin
                color_q <= nxt_col;
                dir_q   <= nxt_dir;
            end
            COLOR_OUT <= video_ON ? color_q : '0;
        end
    end

    assign dir_down = (dir_q == DIR_DOWN);

endmodule

// File: tb/tb_degradado_param.sv
// Scoreboard bench for degradado_param at default parameters.
// Frame stimulus pushes expected colours; the step monitor pops them.
module tb_degradado_param;

    localparam int FPS = 4;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        video_ON = 1'b1;
    logic [9:0]  ADDRV = '0;
    logic        enable = 1'b1;
    logic [1:0]  mode = 2'd1;
    logic [11:0] color_min = 12'h005;
    logic [11:0] color_max = 12'h8FF;
    logic [11:0] COLOR_OUT;
    logic        step_tick;
    logic        dir_down;

    degradado_param dut (
        .CLK       (CLK),
        .RST       (RST),
        .video_ON  (video_ON),
        .ADDRV     (ADDRV),
        .enable    (enable),
        .mode      (mode),
        .color_min (color_min),
        .color_max (color_max),
        .COLOR_OUT (COLOR_OUT),
        .step_tick (step_tick),
        .dir_down  (dir_down)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [11:0] col;
        logic        dir;
    } exp_t;

    exp_t        sbq[$];
    exp_t        pend_e;
    bit          pend = 0;
    int          total = 0;
    int          bad = 0;
    int          steps_seen = 0;
    logic [11:0] m_col = '0;
    logic        m_dir = 1'b0;
    int          m_pre = 0;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic void mstep();
        logic [3:0] c[3], lo[3], hi[3];
        bit oor, done;
        oor = 0;
        done = 0;
        for (int i = 0; i < 3; i++) begin
            c[i]  = m_col[4*i +: 4];
            lo[i] = color_min[4*i +: 4];
            hi[i] = color_max[4*i +: 4];
            if (c[i] < lo[i]) begin c[i] = lo[i]; oor = 1; end
            else if (c[i] > hi[i]) begin c[i] = hi[i]; oor = 1; end
        end
        if (mode == 2'd2) m_dir = 1'b0;
        if (!oor) begin
            if (mode == 2'd1 && m_dir) begin
                if (m_col == color_min) m_dir = 1'b0;
                else for (int i = 2; i >= 0; i--)
                    if (!done && c[i] > lo[i]) begin c[i]--; done = 1; end
            end else if (mode == 2'd1 || mode == 2'd2) begin
                if (m_col == color_max) begin
                    if (mode == 2'd1) m_dir = 1'b1;
                    else c = lo;
                end else for (int i = 0; i < 3; i++)
                    if (!done && c[i] < hi[i]) begin c[i]++; done = 1; end
            end
        end
        m_col = {c[2], c[1], c[0]};
    endfunction

    task automatic frame(input int hold);
        if (enable) begin
            if (m_pre == FPS - 1) begin
                m_pre = 0;
                mstep();
                sbq.push_back('{m_col, m_dir});
            end else begin
                m_pre++;
            end
        end
        @(posedge CLK); #1 ADDRV = 10'd1;
        repeat (hold) @(posedge CLK);
        #1 ADDRV = 10'd0;
        repeat (5) @(posedge CLK);
        #1;
    endtask

    task automatic do_step();
        repeat (FPS) frame(2);
    endtask

    task automatic step_until(input logic [11:0] target, input int lim);
        int n = 0;
        while (m_col != target && n < lim) begin
            do_step();
            n++;
        end
        check("reach", 32'(COLOR_OUT), 32'(target));
    endtask

    always @(negedge CLK) begin
        if (pend) begin
            check("sb_col", 32'(COLOR_OUT), 32'(pend_e.col));
            check("sb_dir", 32'(dir_down), 32'(pend_e.dir));
            check("st_width", 32'(step_tick), 32'd0);
            pend = 0;
        end
        if (step_tick) begin
            steps_seen++;
            check("sb_avail", 32'(sbq.size() > 0), 32'd1);
            if (sbq.size() > 0) begin
                pend_e = sbq.pop_front();
                pend = 1;
            end
        end
    end

    initial begin
        int base;
        repeat (3) @(posedge CLK);
        #1 RST = 1'b0;
        check("rst_col", 32'(COLOR_OUT), 32'h0);
        check("rst_st", 32'(step_tick), 32'd0);
        check("rst_dir", 32'(dir_down), 32'd0);

        for (int s = 1; s <= 69; s++) begin
            do_step();
            case (s)
                1:  check("b_s1", 32'(COLOR_OUT), 32'h005);
                11: check("b_s11", 32'(COLOR_OUT), 32'h00F);
                12: check("b_s12", 32'(COLOR_OUT), 32'h01F);
                34: check("b_s34", 32'(COLOR_OUT), 32'h8FF);
                35: begin
                    check("b_s35", 32'(COLOR_OUT), 32'h8FF);
                    check("b_s35d", 32'(dir_down), 32'd1);
                end
                36: check("b_s36", 32'(COLOR_OUT), 32'h7FF);
                68: check("b_s68", 32'(COLOR_OUT), 32'h005);
                69: check("b_s69d", 32'(dir_down), 32'd0);
                default: ;
            endcase
        end

        base = steps_seen;
        repeat (8) frame(800);
        check("pre_cnt", 32'(steps_seen - base), 32'd2);
        check("pre_col", 32'(COLOR_OUT), 32'h007);

        mode = 2'd2;
        step_until(12'h8FF, 40);
        mode = 2'd1;
        color_max = 12'h3FF;
        do_step();
        check("oor_col", 32'(COLOR_OUT), 32'h3FF);
        check("oor_dir", 32'(dir_down), 32'd0);
        color_max = 12'h8FF;
        do_step();
        check("oor_up", 32'(COLOR_OUT), 32'h4FF);
        mode = 2'd2;
        step_until(12'h8FF, 40);
        do_step();
        check("wrap_col", 32'(COLOR_OUT), 32'h005);
        check("wrap_dir", 32'(dir_down), 32'd0);

        mode = 2'd0;
        base = steps_seen;
        repeat (10) begin
            do_step();
            check("hold_col", 32'(COLOR_OUT), 32'h005);
        end
        check("hold_cnt", 32'(steps_seen - base), 32'd10);

        mode = 2'd1;
        step_until(12'h4FF, 40);
        @(posedge CLK); #1 video_ON = 1'b0;
        @(posedge CLK); #1;
        check("vid_off", 32'(COLOR_OUT), 32'h000);
        video_ON = 1'b1;
        @(posedge CLK); #1;
        check("vid_on", 32'(COLOR_OUT), 32'h4FF);

        step_until(12'h8FF, 10);
        do_step();
        check("top_dir", 32'(dir_down), 32'd1);
        repeat (3) do_step();
        check("desc", 32'(COLOR_OUT), 32'h5FF);
        frame(2);
        frame(2);
        enable = 1'b0;
        base = steps_seen;
        repeat (20) frame(2);
        check("en_col", 32'(COLOR_OUT), 32'h5FF);
        check("en_dir", 32'(dir_down), 32'd1);
        check("en_cnt", 32'(steps_seen - base), 32'd0);
        enable = 1'b1;
        frame(2);
        check("en_pre3", 32'(steps_seen - base), 32'd0);
        frame(2);
        check("en_pre4", 32'(steps_seen - base), 32'd1);
        check("en_step", 32'(COLOR_OUT), 32'h4FF);

        @(posedge CLK); #1 RST = 1'b1;
        @(posedge CLK); #1;
        check("mrst_col", 32'(COLOR_OUT), 32'h000);
        check("mrst_dir", 32'(dir_down), 32'd0);
        RST = 1'b0;
        m_col = '0;
        m_dir = 1'b0;
        m_pre = 0;
        do_step();
        check("mrst_s1", 32'(COLOR_OUT), 32'h005);

        repeat (4) @(posedge CLK);
        check("sb_empty", 32'(sbq.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
